apb_master_arbiter_ctrl: RTL and testbench

- Shares one APB master port between NUM_REQ on-chip requesters with round-robin arbitration.
- Sequences each granted request through the IDLE/SETUP/ACCESS protocol phases and decodes the address into one of NO_OF_SLAVES PSELx lines.
- Returns read data and error status to the originating requester.
- Sits between the requester fabric and the APB interconnect; it is the RTL counterpart the AVIP slave agents are driven against.

---
 rtl/apb_global_pkg.sv | 24 ++
 rtl/apb_rr_arbiter.sv | 57 +++++
 rtl/apb_master_arbiter_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_apb_master_arbiter_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_global_pkg.sv
// Shared APB definitions: default sizing, FSM state encoding and the
// captured-request record used by the master arbiter.
package apb_global_pkg;

  localparam int NO_OF_SLAVES      = 1;
  localparam int ADDRESS_LENGTH    = 32;
  localparam int DATA_WIDTH        = 32;
  localparam int NUM_REQ           = 2;
  localparam int SLAVE_REGION_BITS = 12;
  localparam int TIMEOUT_CYCLES    = 16;

  typedef enum logic [1:0] {
    IDLE_STATE   = 2'b00,
    SETUP_STATE  = 2'b01,
    ACCESS_STATE = 2'b10
  } operation_states_e;

  typedef struct packed {
    logic                      write;
    logic [ADDRESS_LENGTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     wdata;
  } apb_req_s;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the
// pointer, wrapping; the pointer moves past the winner when it is accepted.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               accept_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // Two passes: first requesters at/above the pointer, then the wrapped ones.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_o && valid_i[i] && (i >= int'(ptr_q))) begin
        any_o      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_o && valid_i[i]) begin
        any_o      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
      end
    end
  end

  // Next pointer is the requester just after the winner, modulo NUM_REQ.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
      ptr_d = (idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  // Pointer register; reset gives requester 0 first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/apb_master_arbiter_ctrl.sv
// APB master shared by several requesters: round-robin grant, SETUP/ACCESS
// sequencing, address decode to PSELx, and response routing back to the
// requester that issued the transfer.
module apb_master_arbiter_ctrl #(
  parameter int NUM_REQ           = apb_global_pkg::NUM_REQ,
  parameter int NO_OF_SLAVES      = apb_global_pkg::NO_OF_SLAVES,
  parameter int ADDRESS_LENGTH    = apb_global_pkg::ADDRESS_LENGTH,
  parameter int DATA_WIDTH        = apb_global_pkg::DATA_WIDTH,
  parameter int SLAVE_REGION_BITS = apb_global_pkg::SLAVE_REGION_BITS,
  parameter int TIMEOUT_CYCLES    = apb_global_pkg::TIMEOUT_CYCLES
) (
  input  logic                              pclk,
  input  logic                              preset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*ADDRESS_LENGTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_err,
  output logic [NO_OF_SLAVES-1:0]           psel,
  output logic                              penable,
  output logic                              pwrite,
  output logic [ADDRESS_LENGTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]             pwdata,
  input  logic                              pready,
  input  logic [DATA_WIDTH-1:0]             prdata,
  input  logic                              pslverr
);

  import apb_global_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  operation_states_e         state_q, state_d;
  apb_req_s                  req_q, req_d;
  logic [NO_OF_SLAVES-1:0]   psel_mask_q, psel_mask_d;
  logic [IDX_W-1:0]          gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0]        arb_grant;
  logic [IDX_W-1:0]          arb_idx;
  logic                      arb_any;
  logic                      accept;
  apb_req_s                  sel_req;
  logic [ADDRESS_LENGTH-1:0] slave_idx;
  logic [NO_OF_SLAVES-1:0]   dec_mask;
  logic                      dec_ok;
  logic [NUM_REQ-1:0]        gnt_onehot;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (pclk),
    .rst      (preset),
    .valid_i  (req_valid),
    .accept_i (accept),
    .grant_o  (arb_grant),
    .idx_o    (arb_idx),
    .any_o    (arb_any)
  );

  // Pick the winning requester's fields and decode its slave region.
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_req.write = req_write[i];
        sel_req.addr  = req_addr[i*ADDRESS_LENGTH +: ADDRESS_LENGTH];
        sel_req.wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    slave_idx = sel_req.addr >> SLAVE_REGION_BITS;
    for (int s = 0; s < NO_OF_SLAVES; s++) begin
      dec_mask[s] = (slave_idx == ADDRESS_LENGTH'(s));
    end
    dec_ok = |dec_mask;
  end

  // Owner of the transfer in flight, as a one-hot response vector.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_onehot[i] = (gnt_idx_q == IDX_W'(i));
    end
  end

  // Grants are only made from IDLE, never while a response is being
  // returned, and never while reset is asserted.
  assign accept = (state_q == IDLE_STATE) && arb_any && !(|rsp_valid_q) && !preset;

  // Next-state and response logic of the transfer FSM.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    psel_mask_d = psel_mask_q;
    gnt_idx_d   = gnt_idx_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE_STATE: begin
        if (accept) begin
          req_d       = sel_req;
          psel_mask_d = dec_mask;
          gnt_idx_d   = arb_idx;
          if (dec_ok) begin
            state_d = SETUP_STATE;
          end else begin
            // Unmapped address: answer with an error, no bus cycle.
            rsp_valid_d = arb_grant;
            rsp_err_d   = 1'b1;
          end
        end
      end
      SETUP_STATE: begin
        state_d = ACCESS_STATE;
      end
      ACCESS_STATE: begin
        if (pready) begin
          state_d     = IDLE_STATE;
          cnt_d       = '0;
          rsp_valid_d = gnt_onehot;
          rsp_err_d   = pslverr;
          rsp_rdata_d = (!req_q.write && !pslverr) ? prdata : '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This is the last allowed wait cycle: abort the transfer.
          state_d     = IDLE_STATE;
          cnt_d       = '0;
          rsp_valid_d = gnt_onehot;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, captured request and response registers.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE_STATE;
      req_q       <= '0;
      psel_mask_q <= '0;
      gnt_idx_q   <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      psel_mask_q <= psel_mask_d;
      gnt_idx_q   <= gnt_idx_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = accept ? arb_grant : '0;
  assign psel      = (state_q != IDLE_STATE) ? psel_mask_q : '0;
  assign penable   = (state_q == ACCESS_STATE);
  assign pwrite    = req_q.write;
  assign paddr     = req_q.addr;
  assign pwdata    = req_q.wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_arbiter_ctrl.sv
// Directed bench for apb_master_arbiter_ctrl with two requesters and two slaves.
module tb_apb_master_arbiter_ctrl;

  localparam int NR = 2;
  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             pclk = 1'b0;
  logic             preset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic [NS-1:0]    psel;
  logic             penable;
  logic             pwrite;
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata;
  logic             pready;
  logic [DW-1:0]    prdata;
  logic             pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  apb_master_arbiter_ctrl #(
    .NUM_REQ           (NR),
    .NO_OF_SLAVES      (NS),
    .ADDRESS_LENGTH    (AW),
    .DATA_WIDTH        (DW),
    .SLAVE_REGION_BITS (12),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]            = w;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
  endtask

  logic [NR-1:0] grants [4];
  int            n;

  initial begin
    preset    = 1'b1;
    req_valid = 2'b01;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;

    // Reset state
    repeat (2) @(posedge pclk);
    #1;
    expect_eq("rst_req_ready", req_ready, 2'b00);
    expect_eq("rst_psel",      psel,      2'b00);
    expect_eq("rst_penable",   penable,   1'b0);
    expect_eq("rst_pwrite",    pwrite,    1'b0);
    expect_eq("rst_paddr",     paddr,     32'h0);
    expect_eq("rst_pwdata",    pwdata,    32'h0);
    expect_eq("rst_rsp_valid", rsp_valid, 2'b00);
    expect_eq("rst_rsp_err",   rsp_err,   1'b0);
    expect_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    req_valid = '0;
    preset    = 1'b0;
    tick();

    // Single write, no wait states
    set_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    pready    = 1'b1;
    req_valid = 2'b01;
    #1;
    expect_eq("wr_req_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    expect_eq("wr_setup_psel",    psel,    2'b01);
    expect_eq("wr_setup_penable", penable, 1'b0);
    expect_eq("wr_setup_pwrite",  pwrite,  1'b1);
    expect_eq("wr_setup_paddr",   paddr,   32'h0000_0010);
    expect_eq("wr_setup_pwdata",  pwdata,  32'hDEAD_BEEF);
    expect_eq("wr_setup_rsp",     rsp_valid, 2'b00);
    tick();
    expect_eq("wr_acc_psel",    psel,    2'b01);
    expect_eq("wr_acc_penable", penable, 1'b1);
    tick();
    expect_eq("wr_rsp_valid", rsp_valid, 2'b01);
    expect_eq("wr_rsp_err",   rsp_err,   1'b0);
    expect_eq("wr_rsp_rdata", rsp_rdata, 32'h0);
    expect_eq("wr_idle_psel", psel,      2'b00);
    expect_eq("wr_idle_pen",  penable,   1'b0);
    expect_eq("wr_idle_addr_hold", paddr, 32'h0000_0010);
    tick();
    expect_eq("wr_rsp_once", rsp_valid, 2'b00);

    // Read from requester 1 with three wait states
    set_req(1, 1'b0, 32'h0000_0024, 32'h0);
    pready    = 1'b0;
    req_valid = 2'b10;
    #1;
    expect_eq("rd_req_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    expect_eq("rd_setup_paddr",  paddr,   32'h0000_0024);
    expect_eq("rd_setup_pwrite", pwrite,  1'b0);
    expect_eq("rd_setup_pen",    penable, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      expect_eq($sformatf("rd_acc%0d_pen", c),   penable, 1'b1);
      expect_eq($sformatf("rd_acc%0d_psel", c),  psel,    2'b01);
      expect_eq($sformatf("rd_acc%0d_paddr", c), paddr,   32'h0000_0024);
      expect_eq($sformatf("rd_acc%0d_rsp", c),   rsp_valid, 2'b00);
    end
    pready = 1'b1;
    prdata = 32'h1234_5678;
    tick();
    expect_eq("rd_rsp_valid", rsp_valid, 2'b10);
    expect_eq("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    expect_eq("rd_rsp_err",   rsp_err,   1'b0);
    pready = 1'b0;
    prdata = '0;
    tick();
    expect_eq("rd_rsp_once", rsp_valid, 2'b00);

    // Both requesters continuously valid: alternate grants
    set_req(0, 1'b1, 32'h0000_0100, 32'h1111_1111);
    set_req(1, 1'b1, 32'h0000_0200, 32'h2222_2222);
    pready    = 1'b1;
    req_valid = 2'b11;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      #1;
      if (req_ready != '0) begin
        grants[n] = req_ready;
        n++;
      end
      tick();
    end
    req_valid = '0;
    expect_eq("rr_count", n,         4);
    expect_eq("rr_g0",    grants[0], 2'b01);
    expect_eq("rr_g1",    grants[1], 2'b10);
    expect_eq("rr_g2",    grants[2], 2'b01);
    expect_eq("rr_g3",    grants[3], 2'b10);
    repeat (3) tick();

    // Decode error: index 2 with only two slaves
    set_req(0, 1'b0, 32'h0000_2000, 32'h0);
    req_valid = 2'b01;
    #1;
    expect_eq("dec_req_ready", req_ready, 2'b01);
    tick();
    set_req(1, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5);
    req_valid = 2'b10;
    #1;
    expect_eq("dec_rsp_valid", rsp_valid, 2'b01);
    expect_eq("dec_rsp_err",   rsp_err,   1'b1);
    expect_eq("dec_psel",      psel,      2'b00);
    expect_eq("dec_penable",   penable,   1'b0);
    expect_eq("dec_no_grant",  req_ready, 2'b00);
    tick();
    expect_eq("dec_rsp_clear", rsp_valid, 2'b00);
    expect_eq("dec_next_grant", req_ready, 2'b10);
    tick();
    req_valid = '0;
    expect_eq("slv1_psel",   psel,   2'b10);
    expect_eq("slv1_pwdata", pwdata, 32'hA5A5_A5A5);
    tick();
    tick();
    expect_eq("slv1_rsp_valid", rsp_valid, 2'b10);
    expect_eq("slv1_rsp_err",   rsp_err,   1'b0);
    tick();

    // Timeout: pready never arrives
    set_req(0, 1'b1, 32'h0000_0030, 32'h3333_3333);
    pready    = 1'b0;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    n = 0;
    while (penable === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    expect_eq("to_access_cycles", n,         16);
    expect_eq("to_rsp_valid",     rsp_valid, 2'b01);
    expect_eq("to_rsp_err",       rsp_err,   1'b1);
    expect_eq("to_psel",          psel,      2'b00);
    pready = 1'b1;
    tick();
    set_req(0, 1'b1, 32'h0000_0040, 32'h4444_4444);
    req_valid = 2'b01;
    #1;
    expect_eq("to_next_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    tick();
    tick();
    expect_eq("to_next_rsp", rsp_valid, 2'b01);
    expect_eq("to_next_err", rsp_err,   1'b0);
    tick();

    // Reset during ACCESS
    set_req(0, 1'b0, 32'h0000_0050, 32'h0);
    set_req(1, 1'b0, 32'h0000_0060, 32'h0);
    pready    = 1'b0;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b11;
    tick();
    expect_eq("rst_mid_pen_before", penable, 1'b1);
    #2;
    preset = 1'b1;
    #1;
    expect_eq("rst_mid_psel",      psel,      2'b00);
    expect_eq("rst_mid_penable",   penable,   1'b0);
    expect_eq("rst_mid_req_ready", req_ready, 2'b00);
    tick();
    expect_eq("rst_mid_rsp", rsp_valid, 2'b00);
    preset = 1'b0;
    #1;
    expect_eq("rst_rel_first_grant", req_ready, 2'b01);
    tick();
    req_valid = '0;
    expect_eq("rst_rel_psel", psel,      2'b01);
    expect_eq("rst_rel_rsp",  rsp_valid, 2'b00);
    pready = 1'b1;
    prdata = 32'h0BAD_F00D;
    tick();
    tick();
    expect_eq("rst_rel_rsp_valid", rsp_valid, 2'b01);
    expect_eq("rst_rel_rdata",     rsp_rdata, 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
